trace_dispatcher: RTL and testbench

//  Buffers trace commands {cmd, addr} in a parametrised FIFO and routes them to the split L1 caches.

---
 rtl/trace_dispatcher.sv | 258 +++++++++++++++++++++++++
 tb/tb_trace_dispatcher.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dispatcher.sv
// trace_dispatcher: FIFO-buffered router for trace commands {cmd, addr}.
// Data ops go to the data-cache channel, fetches to the instruction-cache
// channel, clear/print are broadcast to both. Illegal codes are dropped and
// counted. Per-class access counters saturate; a completed clear zeroes them.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | FIFO empty, no valid asserted
// LOAD    | head of FIFO is registered onto its channel(s), or dropped
// UNI_D   | data-cache channel holds valid until d_ready
// UNI_I   | instruction-cache channel holds valid until i_ready
// BCAST   | both channels hold valid, each until its own handshake
module trace_dispatcher #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_cmd,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [3:0]               d_cmd,
  output logic [ADDR_W-1:0]        d_addr,
  output logic                     i_valid,
  input  logic                     i_ready,
  output logic [3:0]               i_cmd,
  output logic [ADDR_W-1:0]        i_addr,
  output logic                     clear_pulse,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         n_reads,
  output logic [CNT_W-1:0]         n_writes,
  output logic [CNT_W-1:0]         n_fetches,
  output logic [CNT_W-1:0]         n_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_UNI_D = 3'd2;
  localparam logic [2:0] S_UNI_I = 3'd3;
  localparam logic [2:0] S_BCAST = 3'd4;

  localparam logic [1:0] CL_D = 2'd0;
  localparam logic [1:0] CL_I = 2'd1;
  localparam logic [1:0] CL_B = 2'd2;
  localparam logic [1:0] CL_X = 2'd3;

  function automatic logic [1:0] f_class(input logic [3:0] cmd);
    case (cmd)
      4'd0, 4'd1, 4'd3, 4'd4: return CL_D;
      4'd2:                   return CL_I;
      4'd8, 4'd9:             return CL_B;
      default:                return CL_X;
    endcase
  endfunction

  logic [3:0]        r_cmd_mem  [DEPTH];
  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_level;
  logic [2:0]        r_state;
  logic              r_d_done;
  logic              r_i_done;
  logic              r_d_valid;
  logic              r_i_valid;
  logic [3:0]        r_d_cmd;
  logic [3:0]        r_i_cmd;
  logic [ADDR_W-1:0] r_d_addr;
  logic [ADDR_W-1:0] r_i_addr;
  logic              r_clear_pulse;
  logic [CNT_W-1:0]  r_n_reads;
  logic [CNT_W-1:0]  r_n_writes;
  logic [CNT_W-1:0]  r_n_fetches;
  logic [CNT_W-1:0]  r_n_illegal;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [3:0]        w_head_cmd;
  logic [ADDR_W-1:0] w_head_addr;
  logic [1:0]        w_head_cls;
  logic              w_d_hs;
  logic              w_i_hs;
  logic              w_d_done;
  logic              w_i_done;
  logic              w_bc_done;
  logic              w_drop;
  logic              w_clear;
  logic [PTR_W:0]    w_level_nxt;
  logic [2:0]        w_after_pop;

  assign w_full      = (r_level == LVL_FULL);
  assign w_push      = in_valid && !w_full;
  assign w_head_cmd  = r_cmd_mem[r_rptr];
  assign w_head_addr = r_addr_mem[r_rptr];
  assign w_head_cls  = f_class(w_head_cmd);

  // Broadcast completes once each channel has handshaken, now or earlier.
  assign w_d_hs    = r_d_valid && d_ready;
  assign w_i_hs    = r_i_valid && i_ready;
  assign w_d_done  = r_d_done || w_d_hs;
  assign w_i_done  = r_i_done || w_i_hs;
  assign w_bc_done = (r_state == S_BCAST) && w_d_done && w_i_done;
  assign w_drop    = (r_state == S_LOAD) && (w_head_cls == CL_X);
  assign w_clear   = w_bc_done && (w_head_cmd == 4'd8);

  // The head entry stays in the FIFO until its dispatch completes.
  assign w_pop = w_drop
              || ((r_state == S_UNI_D) && w_d_hs)
              || ((r_state == S_UNI_I) && w_i_hs)
              || w_bc_done;

  assign w_level_nxt = r_level + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
  assign w_after_pop = (w_level_nxt != '0) ? S_LOAD : S_IDLE;

  assign in_ready    = !w_full;
  assign level       = r_level;
  assign d_valid     = r_d_valid;
  assign d_cmd       = r_d_cmd;
  assign d_addr      = r_d_addr;
  assign i_valid     = r_i_valid;
  assign i_cmd       = r_i_cmd;
  assign i_addr      = r_i_addr;
  assign clear_pulse = r_clear_pulse;
  assign n_reads     = r_n_reads;
  assign n_writes    = r_n_writes;
  assign n_fetches   = r_n_fetches;
  assign n_illegal   = r_n_illegal;

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cmd_mem[r_wptr]  <= in_cmd;
      r_addr_mem[r_wptr] <= in_addr;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_level <= w_level_nxt;
    end
  end

  // Dispatch FSM and registered channel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_d_done      <= 1'b0;
      r_i_done      <= 1'b0;
      r_d_valid     <= 1'b0;
      r_i_valid     <= 1'b0;
      r_d_cmd       <= '0;
      r_i_cmd       <= '0;
      r_d_addr      <= '0;
      r_i_addr      <= '0;
      r_clear_pulse <= 1'b0;
    end else begin
      r_clear_pulse <= w_clear;
      case (r_state)
        S_IDLE: begin
          if (r_level != '0) r_state <= S_LOAD;
        end
        S_LOAD: begin
          case (w_head_cls)
            CL_D: begin
              r_d_valid <= 1'b1;
              r_d_cmd   <= w_head_cmd;
              r_d_addr  <= w_head_addr;
              r_state   <= S_UNI_D;
            end
            CL_I: begin
              r_i_valid <= 1'b1;
              r_i_cmd   <= w_head_cmd;
              r_i_addr  <= w_head_addr;
              r_state   <= S_UNI_I;
            end
            CL_B: begin
              r_d_valid <= 1'b1;
              r_d_cmd   <= w_head_cmd;
              r_d_addr  <= w_head_addr;
              r_i_valid <= 1'b1;
              r_i_cmd   <= w_head_cmd;
              r_i_addr  <= w_head_addr;
              r_d_done  <= 1'b0;
              r_i_done  <= 1'b0;
              r_state   <= S_BCAST;
            end
            default: r_state <= w_after_pop;
          endcase
        end
        S_UNI_D: begin
          if (w_d_hs) begin
            r_d_valid <= 1'b0;
            r_state   <= w_after_pop;
          end
        end
        S_UNI_I: begin
          if (w_i_hs) begin
            r_i_valid <= 1'b0;
            r_state   <= w_after_pop;
          end
        end
        S_BCAST: begin
          if (w_d_hs) r_d_valid <= 1'b0;
          if (w_i_hs) r_i_valid <= 1'b0;
          if (w_bc_done) begin
            r_d_done <= 1'b0;
            r_i_done <= 1'b0;
            r_state  <= w_after_pop;
          end else begin
            r_d_done <= w_d_done;
            r_i_done <= w_i_done;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating statistics; a completed clear takes priority over any increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n_reads   <= '0;
      r_n_writes  <= '0;
      r_n_fetches <= '0;
      r_n_illegal <= '0;
    end else if (w_clear) begin
      r_n_reads   <= '0;
      r_n_writes  <= '0;
      r_n_fetches <= '0;
      r_n_illegal <= '0;
    end else begin
      if ((r_state == S_UNI_D) && w_d_hs && (w_head_cmd == 4'd0) && (r_n_reads != '1))
        r_n_reads <= r_n_reads + CNT_W'(1);
      if ((r_state == S_UNI_D) && w_d_hs && (w_head_cmd == 4'd1) && (r_n_writes != '1))
        r_n_writes <= r_n_writes + CNT_W'(1);
      if ((r_state == S_UNI_I) && w_i_hs && (r_n_fetches != '1))
        r_n_fetches <= r_n_fetches + CNT_W'(1);
      if (w_drop && (r_n_illegal != '1))
        r_n_illegal <= r_n_illegal + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trace_dispatcher.sv
// Bench for trace_dispatcher: transaction-level queue model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_trace_dispatcher;

  localparam int AW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_cmd = '0;
  logic [AW-1:0] in_addr = '0;
  logic          d_ready = 1'b0;
  logic          i_ready = 1'b0;
  logic          in_ready, d_valid, i_valid, clear_pulse;
  logic [3:0]    d_cmd, i_cmd;
  logic [AW-1:0] d_addr, i_addr;
  logic [LW-1:0] level;
  logic [CW-1:0] n_reads, n_writes, n_fetches, n_illegal;

  trace_dispatcher #(.ADDR_W(AW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .d_valid(d_valid), .d_ready(d_ready), .d_cmd(d_cmd), .d_addr(d_addr),
    .i_valid(i_valid), .i_ready(i_ready), .i_cmd(i_cmd), .i_addr(i_addr),
    .clear_pulse(clear_pulse), .level(level),
    .n_reads(n_reads), .n_writes(n_writes), .n_fetches(n_fetches), .n_illegal(n_illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 = data channel, 1 = instruction channel, 2 = broadcast, 3 = illegal
  function automatic int cls(input logic [3:0] c);
    if (c == 4'd0 || c == 4'd1 || c == 4'd3 || c == 4'd4) return 0;
    if (c == 4'd2) return 1;
    if (c == 4'd8 || c == 4'd9) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a;
  } ent_t;

  // Model: pending commands in arrival order, whether the head is on the
  // channels, whether it will be taken up at the next edge, broadcast progress.
  ent_t        q[$];
  bit          m_pres = 0;
  bit          m_pend = 0;
  bit          m_dd = 0;
  bit          m_id = 0;
  bit          m_clear = 0;
  logic [31:0] m_rd = 0, m_wr = 0, m_fe = 0, m_il = 0;
  bit          t_push, t_pop, t_clear, t_nonempty, t_was_pres, t_was_pend, t_ill, t_done;
  logic [3:0]  t_c;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_pres = 0; m_pend = 0; m_dd = 0; m_id = 0; m_clear = 0;
      m_rd = 0; m_wr = 0; m_fe = 0; m_il = 0;
    end else begin
      t_push = in_valid && (q.size() < DEPTH);
      t_pop = 0; t_clear = 0; t_ill = 0; t_done = 0;
      t_nonempty = (q.size() != 0);
      t_was_pres = m_pres;
      t_was_pend = m_pend;
      if (m_pres) begin
        t_c = q[0].c;
        case (cls(t_c))
          0: t_done = d_ready;
          1: t_done = i_ready;
          default: begin
            m_dd = m_dd | d_ready;
            m_id = m_id | i_ready;
            t_done = m_dd && m_id;
          end
        endcase
        if (t_done) begin
          t_pop = 1; m_pres = 0; m_dd = 0; m_id = 0;
          if (t_c == 4'd0) m_rd = sat_inc(m_rd);
          if (t_c == 4'd1) m_wr = sat_inc(m_wr);
          if (t_c == 4'd2) m_fe = sat_inc(m_fe);
          if (t_c == 4'd8) begin
            t_clear = 1; m_rd = 0; m_wr = 0; m_fe = 0; m_il = 0;
          end
        end
      end else if (m_pend) begin
        if (cls(q[0].c) == 3) begin
          t_pop = 1; t_ill = 1; m_il = sat_inc(m_il);
        end else begin
          m_pres = 1;
        end
      end
      if (t_push) q.push_back(ent_t'{in_cmd, in_addr});
      if (t_pop) void'(q.pop_front());
      if (t_was_pres)      m_pend = t_pop && (q.size() != 0);
      else if (t_was_pend) m_pend = t_ill && (q.size() != 0);
      else                 m_pend = t_nonempty;
      m_clear = t_clear;
    end
  end

  // Per-cycle comparison against the model.
  bit e_d, e_i;
  always @(negedge clk) begin
    e_d = m_pres && (q.size() != 0) && (cls(q[0].c) == 0 || (cls(q[0].c) == 2 && !m_dd));
    e_i = m_pres && (q.size() != 0) && (cls(q[0].c) == 1 || (cls(q[0].c) == 2 && !m_id));
    chk("in_ready", in_ready, (q.size() < DEPTH));
    chk("level", level, q.size());
    chk("d_valid", d_valid, e_d);
    chk("i_valid", i_valid, e_i);
    if (e_d) begin
      chk("d_cmd", d_cmd, q[0].c);
      chk("d_addr", d_addr, q[0].a);
    end
    if (e_i) begin
      chk("i_cmd", i_cmd, q[0].c);
      chk("i_addr", i_addr, q[0].a);
    end
    chk("clear_pulse", clear_pulse, m_clear);
    chk("n_reads", n_reads, m_rd);
    chk("n_writes", n_writes, m_wr);
    chk("n_fetches", n_fetches, m_fe);
    chk("n_illegal", n_illegal, m_il);
  end

  task automatic push(input logic [3:0] c, input logic [31:0] a);
    in_valid = 1'b1; in_cmd = c; in_addr = a;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // which: 0 = d_valid, 1 = i_valid, 2 = clear_pulse; lat = -1 on timeout
  task automatic wait_sig(input int which, output int lat);
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if ((which == 0 && d_valid) || (which == 1 && i_valid) || (which == 2 && clear_pulse)) begin
        lat = k;
        return;
      end
      @(negedge clk);
    end
  endtask

  int          lat, n, got;
  bit          anyv;
  int          ev_ch[2];
  logic [31:0] ev_addr[2];

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_i_valid", i_valid, 0);
    chk("rst_counters", {n_reads | n_writes | n_fetches | n_illegal}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single read, ready high: two-edge latency, one-cycle valid.
    d_ready = 1'b1;
    push(4'd0, 32'h984D_E132);
    wait_sig(0, lat);
    chk("t2_latency", lat, 2);
    chk("t2_d_addr", d_addr, 32'h984D_E132);
    n = 0;
    while (d_valid && n < 10) begin n++; @(negedge clk); end
    chk("t2_valid_width", n, 1);
    repeat (2) @(negedge clk);
    chk("t2_n_reads", n_reads, 1);
    chk("t2_level", level, 0);

    // Fill to full with the sink stalled, then drain in order.
    d_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_cmd = 4'(i % 2); in_addr = 32'h1000 + i;
      @(negedge clk);
      if (i == 7) begin
        chk("t3_level_full", level, 8);
        chk("t3_in_ready_full", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    chk("t3_level_after9", level, 8);
    d_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 60 && got < 8; k++) begin
      if (d_valid) begin
        chk($sformatf("t3_order%0d", got), d_addr, 32'h1000 + got);
        got++;
      end
      @(negedge clk);
    end
    chk("t3_dispatched", got, 8);
    repeat (3) @(negedge clk);
    chk("t3_n_reads", n_reads, 5);
    chk("t3_n_writes", n_writes, 4);
    chk("t3_level_empty", level, 0);

    // Fetch then write: routed to separate channels in order.
    i_ready = 1'b1;
    push(4'd2, 32'h846D_E107);
    push(4'd1, 32'h777D_E133);
    got = 0;
    for (int k = 0; k < 30 && got < 2; k++) begin
      if (i_valid && got < 2) begin ev_ch[got] = 1; ev_addr[got] = i_addr; got++; end
      if (d_valid && got < 2) begin ev_ch[got] = 0; ev_addr[got] = d_addr; got++; end
      @(negedge clk);
    end
    chk("t4_events", got, 2);
    chk("t4_first_ch", ev_ch[0], 1);
    chk("t4_first_addr", ev_addr[0], 32'h846D_E107);
    chk("t4_second_ch", ev_ch[1], 0);
    chk("t4_second_addr", ev_addr[1], 32'h777D_E133);
    repeat (3) @(negedge clk);
    chk("t4_n_fetches", n_fetches, 1);
    chk("t4_n_writes", n_writes, 5);

    // Print broadcast with the instruction side stalled.
    i_ready = 1'b0;
    push(4'd9, 32'hABCD_0009);
    wait_sig(0, lat);
    chk("t5_d_seen", lat >= 0, 1);
    chk("t5_i_valid_with_d", i_valid, 1);
    @(negedge clk);
    chk("t5_d_dropped", d_valid, 0);
    chk("t5_i_held", i_valid, 1);
    chk("t5_no_pop", level, 1);
    repeat (2) @(negedge clk);
    chk("t5_i_still_held", i_valid, 1);
    chk("t5_still_no_pop", level, 1);
    i_ready = 1'b1;
    @(negedge clk);
    chk("t5_i_done", i_valid, 0);
    chk("t5_popped", level, 0);

    // Clear broadcast zeroes counters with a one-cycle pulse; then an illegal code.
    push(4'd8, 32'h0000_0008);
    wait_sig(2, lat);
    chk("t6_pulse_seen", lat >= 0, 1);
    chk("t6_reads_zero", n_reads, 0);
    chk("t6_writes_zero", n_writes, 0);
    chk("t6_fetches_zero", n_fetches, 0);
    @(negedge clk);
    chk("t6_pulse_width", clear_pulse, 0);
    push(4'd5, 32'h0000_0055);
    anyv = 0;
    for (int k = 0; k < 8; k++) begin
      anyv |= d_valid | i_valid;
      @(negedge clk);
    end
    chk("t6_no_valid", anyv, 0);
    chk("t6_n_illegal", n_illegal, 1);
    chk("t6_level", level, 0);

    // Reset mid-dispatch drops everything.
    d_ready = 1'b0;
    push(4'd1, 32'h0000_0011);
    push(4'd0, 32'h0000_0022);
    wait_sig(0, lat);
    chk("t7_d_seen", lat >= 0, 1);
    #2 rst = 1'b0;
    #1;
    chk("t7_abort_valid", d_valid, 0);
    chk("t7_abort_level", level, 0);
    chk("t7_abort_pulse", clear_pulse, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    d_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t7_nothing_dispatched", n_writes, 0);
    chk("t7_illegal_cleared", n_illegal, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
